// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and types for the Execute stage: icodes, condition
// functions, status codes, condition-code layout and the E->M register image.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: INOP, cnd: 1'b0,
                                  valE: 64'd0, valA: 64'd0,
                                  dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/exec_cc_stage_cond_eval.sv
// Combinational evaluation of the jump / conditional-move condition from
// the condition codes; undefined function codes evaluate false.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  cc_t        cc,
  output logic       cnd
);

  logic w_lt;
  assign w_lt = cc.sf ^ cc.of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = w_lt | cc.zf;
      C_L:     cnd = w_lt;
      C_E:     cnd = cc.zf;
      C_NE:    cnd = ~cc.zf;
      C_GE:    cnd = ~w_lt;
      C_G:     cnd = ~w_lt & ~cc.zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// Y86-64 Execute stage: condition codes, cmov cancellation and the E->M
// pipeline register. Define CC_EXC_SUPPRESS_EN to freeze flags behind exceptions.
module exec_cc_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [63:0] alu_sum,
  input  logic        alu_of,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic        e_cnd,
  output logic [3:0]  e_dstE,
  output logic [2:0]  cc,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  cc_t    r_cc;
  m_reg_t r_m;
  m_reg_t w_m_next;
  logic   w_cond;
  logic   w_flags_ok;
  logic   w_set_cc;
  cc_t    w_cc_next;

  cond_eval u_cond_eval (
    .ifun (E_ifun),
    .cc   (r_cc),
    .cnd  (w_cond)
  );

  // Stage E: condition result and cmov destination cancellation
  assign e_cnd  = ((E_icode == IRRMOVQ) || (E_icode == IJXX)) ? w_cond : 1'b1;
  assign e_dstE = ((E_icode == IRRMOVQ) && !e_cnd) ? RNONE : E_dstE;

`ifdef CC_EXC_SUPPRESS_EN
  assign w_flags_ok = (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
`else
  logic w_unused_stat;
  assign w_unused_stat = ^{m_stat, W_stat};
  assign w_flags_ok    = 1'b1;
`endif

  assign w_set_cc  = (E_icode == IOPQ) && !M_stall && w_flags_ok;
  assign w_cc_next = '{zf: (alu_sum == 64'd0), sf: alu_sum[63], of: alu_of};

  always_comb begin
    w_m_next = r_m;
    if (!M_stall) begin
      if (M_bubble) begin
        w_m_next = M_BUBBLE;
      end else begin
        w_m_next = '{stat: E_stat, icode: E_icode, cnd: e_cnd, valE: alu_sum,
                     valA: E_valA, dstE: e_dstE, dstM: E_dstM};
      end
    end
  end

  // Stage E -> M boundary: flags and pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cc <= CC_RESET;
      r_m  <= M_BUBBLE;
    end else begin
      if (w_set_cc) begin
        r_cc <= w_cc_next;
      end
      r_m <= w_m_next;
    end
  end

  assign cc      = r_cc;
  assign M_stat  = r_m.stat;
  assign M_icode = r_m.icode;
  assign M_cnd   = r_m.cnd;
  assign M_valE  = r_m.valE;
  assign M_valA  = r_m.valA;
  assign M_dstE  = r_m.dstE;
  assign M_dstM  = r_m.dstM;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exec_cc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valA;
  logic [3:0]  E_dstE, E_dstM;
  logic [63:0] alu_sum;
  logic        alu_of;
  logic [2:0]  m_stat, W_stat;
  logic        M_stall, M_bubble;
  logic        e_cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  cc;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit        mz, ms, mo;
  bit [2:0]  mM_stat;
  bit [3:0]  mM_icode;
  bit        mM_cnd;
  bit [63:0] mM_valE, mM_valA;
  bit [3:0]  mM_dstE, mM_dstM;

  exec_cc_stage dut (
    .clk(clk), .reset(reset), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_sum(alu_sum),
    .alu_of(alu_of), .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall),
    .M_bubble(M_bubble), .e_cnd(e_cnd), .e_dstE(e_dstE), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed-compare semantics of the flags, phrased as the Y86 condition table
  function automatic bit model_cond(input bit [3:0] f);
    bit less;
    less = ms ^ mo;
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || mz;
      4'd2: return less;
      4'd3: return mz;
      4'd4: return !mz;
      4'd5: return !less;
      4'd6: return !less && !mz;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_ecnd();
    if (E_icode == 4'd2 || E_icode == 4'd7) return model_cond(E_ifun);
    return 1'b1;
  endfunction

  function automatic bit [3:0] model_edst();
    if (E_icode == 4'd2 && !model_ecnd()) return 4'hF;
    return E_dstE;
  endfunction

  task automatic model_reset();
    {mz, ms, mo} = 3'b100;
    mM_stat = 3'd1; mM_icode = 4'd1; mM_cnd = 1'b0;
    mM_valE = '0; mM_valA = '0; mM_dstE = 4'hF; mM_dstM = 4'hF;
  endtask

  task automatic model_clock();
    bit upd;
    bit c;
    bit [3:0] d;
    if (reset) begin
      model_reset();
      return;
    end
    c = model_ecnd();
    d = model_edst();
    upd = (E_icode == 4'd6) && !M_stall;
`ifdef CC_EXC_SUPPRESS_EN
    upd = upd && (m_stat == 3'd1) && (W_stat == 3'd1);
`endif
    if (!M_stall) begin
      if (M_bubble) begin
        mM_stat = 3'd1; mM_icode = 4'd1; mM_cnd = 1'b0;
        mM_valE = '0; mM_valA = '0; mM_dstE = 4'hF; mM_dstM = 4'hF;
      end else begin
        mM_stat = E_stat; mM_icode = E_icode; mM_cnd = c;
        mM_valE = alu_sum; mM_valA = E_valA; mM_dstE = d; mM_dstM = E_dstM;
      end
    end
    if (upd) begin
      mz = (alu_sum == 64'd0);
      ms = alu_sum[63];
      mo = alu_of;
    end
  endtask

  task automatic compare_all();
    check("e_cnd",   e_cnd,   model_ecnd());
    check("e_dstE",  e_dstE,  model_edst());
    check("cc",      cc,      {mz, ms, mo});
    check("M_stat",  M_stat,  mM_stat);
    check("M_icode", M_icode, mM_icode);
    check("M_cnd",   M_cnd,   mM_cnd);
    check("M_valE",  M_valE,  mM_valE);
    check("M_valA",  M_valA,  mM_valA);
    check("M_dstE",  M_dstE,  mM_dstE);
    check("M_dstM",  M_dstM,  mM_dstM);
  endtask

  // Called at a negedge with fresh inputs applied; returns at the next negedge
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_in(input bit [3:0] icode, input bit [3:0] ifun, input bit [63:0] sum,
                        input bit of, input bit [3:0] dste, input bit stall, input bit bubble);
    E_stat = 3'd1; E_icode = icode; E_ifun = ifun; E_valA = 64'h1234_5678_9ABC_DEF0;
    E_dstE = dste; E_dstM = 4'h7; alu_sum = sum; alu_of = of;
    m_stat = 3'd1; W_stat = 3'd1; M_stall = stall; M_bubble = bubble;
  endtask

  task automatic randomize_in();
    int k;
    k = $urandom_range(0, 3);
    E_icode = (k == 0) ? 4'd2 : (k == 1) ? 4'd6 : (k == 2) ? 4'd7 : 4'($urandom_range(0, 15));
    E_ifun  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
    E_stat  = 3'($urandom_range(1, 4));
    E_valA  = {$urandom, $urandom};
    E_dstE  = 4'($urandom);
    E_dstM  = 4'($urandom);
    k = $urandom_range(0, 3);
    alu_sum = (k == 0) ? 64'd0 : (k == 1) ? {1'b1, 63'($urandom)} : {$urandom, $urandom};
    alu_of  = 1'($urandom);
    m_stat  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    W_stat  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    M_stall  = ($urandom_range(0, 4) == 0);
    M_bubble = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(4'd1, 4'd0, 64'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and condition evaluation on reset flags
    set_in(4'd7, 4'd3, 64'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    #1;
    check("rst_cc", cc, 3'b100);
    check("rst_M_icode", M_icode, 4'd1);
    check("rst_M_dstE", M_dstE, 4'hF);
    check("jxx_e_after_rst", e_cnd, 1'b1);
    E_ifun = 4'd4;
    #1;
    check("jxx_ne_after_rst", e_cnd, 1'b0);
    tick();

    // OPq sets SF and OF; following cmovl is cancelled
    set_in(4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b1, 4'h3, 1'b0, 1'b0);
    #1;
    check("opq_no_self_flags", cc, 3'b100);
    tick();
    check("opq_cc_neg_of", cc, 3'b011);
    set_in(4'd2, 4'd2, 64'd9, 1'b0, 4'h5, 1'b0, 1'b0);
    #1;
    check("cmovl_cnd", e_cnd, 1'b0);
    check("cmovl_dstE", e_dstE, 4'hF);
    tick();
    check("cmovl_M_dstE", M_dstE, 4'hF);

    // Stalled OPq must not touch flags or the M register
    set_in(4'd6, 4'd0, 64'd0, 1'b0, 4'h2, 1'b1, 1'b0);
    tick();
    check("stall_cc_held", cc, 3'b011);
    check("stall_M_icode_held", M_icode, 4'd2);
    M_stall = 1'b0;
    tick();
    check("release_cc_zero", cc, 3'b100);

    // Stall beats bubble; bubble alone inserts a NOP
    set_in(4'd4, 4'd0, 64'd40, 1'b0, 4'h3, 1'b0, 1'b0);
    tick();
    check("adv_M_dstE", M_dstE, 4'h3);
    set_in(4'd5, 4'd0, 64'd7, 1'b0, 4'h6, 1'b1, 1'b1);
    tick();
    tick();
    check("stallbub_M_dstE", M_dstE, 4'h3);
    check("stallbub_M_valE", M_valE, 64'd40);
    M_stall = 1'b0;
    tick();
    check("bubble_M_icode", M_icode, 4'd1);
    check("bubble_M_dstE", M_dstE, 4'hF);
    check("bubble_M_valE", M_valE, 64'd0);

    // OPq behind an address exception
    set_in(4'd6, 4'd0, 64'd5, 1'b0, 4'h1, 1'b0, 1'b0);
    m_stat = 3'd3;
    tick();
`ifdef CC_EXC_SUPPRESS_EN
    check("exc_cc", cc, 3'b100);
`else
    check("exc_cc", cc, 3'b000);
`endif

    // Asynchronous reset mid-cycle during an OPq
    set_in(4'd6, 4'd0, 64'h8000_0000_0000_0001, 1'b1, 4'h4, 1'b0, 1'b0);
    tick();
    set_in(4'd6, 4'd0, 64'd0, 1'b0, 4'h4, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_cc", cc, 3'b100);
    check("async_rst_M_icode", M_icode, 4'd1);
    check("async_rst_M_dstE", M_dstE, 4'hF);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_cc", cc, 3'b100);
    check("rst_hold_M_valE", M_valE, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    set_in(4'd6, 4'd0, 64'h8000_0000_0000_0000, 1'b0, 4'h4, 1'b0, 1'b0);
    tick();
    check("post_rst_cc", cc, 3'b010);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      randomize_in();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_cc_stage.md
EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (data 64, icode/ifun/reg-id 4, stat 3).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 E_stat/E_icode/E_ifun  in  3/4/4  status, icode and function of the instruction in Execute.
REQ-005 E_valA  in  64  operand A passed through to Memory.
REQ-006 E_dstE/E_dstM  in  4/4  destination register ids (0xF = RNONE).
REQ-007 alu_sum/alu_of  in  64/1  result and overflow flag from the 64-bit ALU adder for the current Execute instruction.
REQ-008 m_stat/W_stat  in  3/3  status of the instructions in Memory and Writeback.
REQ-009 M_stall/M_bubble  in  1/1  pipeline control for the E->M register.
REQ-010 e_cnd  out  1  combinational condition result for the Execute instruction.
REQ-011 e_dstE  out  4  combinational dstE after conditional-move cancellation.
REQ-012 cc  out  3  registered condition codes {ZF,SF,OF}.
REQ-013 M_stat/M_icode/M_cnd/M_valE/M_valA/M_dstE/M_dstM  out  3/4/1/64/64/4/4  registered E->M pipeline outputs.

Function
REQ-014 Condition evaluation SHALL use the registered cc: ifun 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF; ifun 7-15 SHALL yield 0.
REQ-015 e_cnd SHALL be the evaluation result when E_icode is IRRMOVQ(2) or IJXX(7), else 1.
REQ-016 e_dstE SHALL equal RNONE when E_icode==IRRMOVQ and e_cnd==0, else E_dstE.
REQ-017 set_cc SHALL be E_icode==IOPQ(6) and M_stall==0 (qualified further per REQ-027).
REQ-018 When set_cc, on the next edge cc SHALL load ZF=(alu_sum==0), SF=alu_sum[63], OF=alu_of; otherwise cc SHALL hold.
REQ-019 An OPq in Execute SHALL NOT see its own flag update; the next Execute instruction sees it (1-cycle latency, no forwarding).
REQ-020 Normal advance (M_stall=0, M_bubble=0): M register SHALL load E_stat, E_icode, e_cnd, alu_sum, E_valA, e_dstE, E_dstM.
REQ-021 M_bubble=1, M_stall=0: M register SHALL load the bubble: stat AOK(1), icode INOP(1), cnd 0, valE 0, valA 0, dstE RNONE, dstM RNONE.
REQ-022 M_stall=1: M register SHALL hold all fields; M_stall SHALL take priority over simultaneous M_bubble.
REQ-023 Any E_icode value SHALL be passed through unmodified; no decoding errors are raised here.

Reset
REQ-024 On reset assertion, cc SHALL immediately become {ZF=1,SF=0,OF=0}.
REQ-025 On reset assertion, the M register SHALL immediately take the bubble value of REQ-021.
REQ-026 Reset asserted mid-operation SHALL discard any pending cc update and pipeline contents; first edge after deassertion behaves per REQ-020..022.

Configuration
REQ-027 With CC_EXC_SUPPRESS_EN defined, set_cc SHALL additionally require m_stat==AOK and W_stat==AOK (flags frozen behind an exception); without it, m_stat/W_stat SHALL be ignored (ports retained).

Structure
REQ-028 Package y86_pkg SHALL hold icode constants, ifun condition codes, stat codes (AOK=1,HLT=2,ADR=3,INS=4), RNONE, and the cc struct/bit indices.
REQ-029 One combinational sub-module cond_eval (inputs ifun, cc; output cnd) SHALL implement REQ-014.

Verification
REQ-030 After reset, cc=3'b100; E_icode=IJXX, ifun=3 (e) -> e_cnd=1; ifun=4 -> e_cnd=0; M_icode=INOP, M_dstE=0xF.
REQ-031 OPq with alu_sum=64'h8000_0000_0000_0000, alu_of=1 -> next cycle cc={0,1,1}; following IRRMOVQ ifun=2 (l) -> e_cnd=0, e_dstE=0xF, M_dstE=0xF one cycle later.
REQ-032 OPq alu_sum=0, alu_of=0 with M_stall=1 -> cc unchanged and M outputs held; release stall -> cc={1,0,0} next edge.
REQ-033 M_stall=1 and M_bubble=1 together for 2 cycles -> M outputs hold previous values; M_bubble alone -> bubble values next edge.
REQ-034 CC_EXC_SUPPRESS_EN defined, m_stat=ADR(3), OPq alu_sum=5 -> cc unchanged; macro undefined, same stimulus -> cc={0,0,0}.
REQ-035 Reset asserted asynchronously between edges during OPq -> cc=3'b100 and M bubble immediately, no update at next edge while reset high.
